// File: rtl/dds_cmd_pkg.sv
// Shared constants for the UART command parser that programs the DDS core.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dds_cmd_pkg;

  // Frame delimiter and opcodes
  localparam logic [7:0] HDR_BYTE = 8'h55;
  localparam logic [7:0] OP_FREQ  = 8'h01;
  localparam logic [7:0] OP_PHASE = 8'h02;
  localparam logic [7:0] OP_WAVE  = 8'h03;

  // wave_sel encoding
  localparam logic [1:0] WAVE_SINE     = 2'd0;
  localparam logic [1:0] WAVE_TRIANGLE = 2'd1;
  localparam logic [1:0] WAVE_SQUARE   = 2'd2;
  localparam logic [1:0] WAVE_SAWTOOTH = 2'd3;

  // Parser FSM
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPCODE  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  // True for opcodes that map to a register
  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_FREQ) || (op == OP_PHASE) || (op == OP_WAVE);
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Parses 7-byte UART frames (55 op P3 P2 P1 P0 csum) into DDS config registers.
// Latency: register write + cfg_update/frame_err visible the cycle after the checksum byte edge.
// Backpressure: none; one byte per rx_done rising edge. Optional inter-byte timeout: UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
  import dds_cmd_pkg::*;
#(
  parameter int unsigned FREQ       = 50000000,
  parameter int unsigned TIMEOUT_US = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [31:0] freq_word,
  output logic [15:0] phase_word,
  output logic [1:0]  wave_sel,
  output logic        cfg_update,
  output logic        frame_err
);

  // Timeout length in sys_clk cycles; a zero-length timeout is meaningless.
  localparam int unsigned TMO_CYCLES = FREQ / 1000000 * TIMEOUT_US;

  if (TMO_CYCLES == 0) begin : g_bad_cfg
    $error("uart_cmd_parser: FREQ/1000000*TIMEOUT_US must be at least 1");
  end

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rx_done_q, rx_done_d;
  logic [31:0] freq_word_q, freq_word_d;
  logic [15:0] phase_word_q, phase_word_d;
  logic [1:0]  wave_sel_q, wave_sel_d;
  logic        cfg_update_q, cfg_update_d;
  logic        frame_err_q, frame_err_d;
  logic        byte_edge;
  logic        tmo_expired;

  // A held rx_done level counts once: only the low-to-high transition is a byte.
  assign byte_edge = rx_done & ~rx_done_q;
  assign rx_done_d = rx_done;

`ifdef UART_CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // Timeout counter: reload on every accepted byte, count down while mid-frame.
  // A byte edge in the expiry cycle wins because expiry is masked by byte_edge.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    tmo_expired = 1'b0;
    if (byte_edge) begin
      tmo_cnt_d = 32'(TMO_CYCLES - 1);
    end else if (state_q != ST_IDLE) begin
      if (tmo_cnt_q == 32'd0) begin
        tmo_expired = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q - 32'd1;
      end
    end
  end

  // Timeout counter register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_expired = 1'b0;
`endif

  // Next-state, frame assembly, checksum and register commit.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    csum_d       = csum_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    freq_word_d  = freq_word_q;
    phase_word_d = phase_word_q;
    wave_sel_d   = wave_sel_q;
    cfg_update_d = 1'b0;
    frame_err_d  = 1'b0;

    if (byte_edge) begin
      case (state_q)
        ST_IDLE: begin
          // Anything other than the header is line noise and dropped silently
          if (rx_data == HDR_BYTE) begin
            state_d = ST_OPCODE;
          end
        end
        ST_OPCODE: begin
          opcode_d = rx_data;
          csum_d   = rx_data;
          cnt_d    = 2'd0;
          state_d  = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          buf_d  = {buf_q[23:0], rx_data};
          csum_d = csum_q + rx_data;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if ((rx_data == csum_q) && is_known_op(opcode_q)) begin
            cfg_update_d = 1'b1;
            case (opcode_q)
              OP_FREQ:  freq_word_d  = buf_q;
              OP_PHASE: phase_word_d = buf_q[15:0];
              default:  wave_sel_d   = buf_q[1:0];
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_expired) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      opcode_q     <= '0;
      csum_q       <= '0;
      buf_q        <= '0;
      cnt_q        <= '0;
      rx_done_q    <= 1'b0;
      freq_word_q  <= '0;
      phase_word_q <= '0;
      wave_sel_q   <= WAVE_SINE;
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      csum_q       <= csum_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      rx_done_q    <= rx_done_d;
      freq_word_q  <= freq_word_d;
      phase_word_q <= phase_word_d;
      wave_sel_q   <= wave_sel_d;
      cfg_update_q <= cfg_update_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign freq_word  = freq_word_q;
  assign phase_word = phase_word_q;
  assign wave_sel   = wave_sel_q;
  assign cfg_update = cfg_update_q;
  assign frame_err  = frame_err_q;

endmodule
